// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing one wordline decoder between NREQ requesters, with a
// dead cycle after every access and a full-range address sweep mode.
module decoder_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      sweep_start,
  output logic [ADDR_W-1:0]         dec_addr,
  output logic                      dec_en,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CntW-1:0]   HoldInit = CntW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] AddrLast = '1;
  localparam logic [IdW-1:0]    IdLast   = IdW'(NREQ - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSweepOn,
    StSweepGap
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
  logic              dec_en_q, dec_en_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [IdW-1:0]    gnt_id_q, gnt_id_d;
  logic              sweep_done_q, sweep_done_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;

  // Unpack the request address bus so the winner can be selected by index.
  logic [ADDR_W-1:0] addr_arr [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_arr[k] = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  logic           found;
  logic [IdW-1:0] pick;
  logic [IdW-1:0] idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IdW'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dec_addr_q   <= '0;
      dec_en_q     <= 1'b0;
      req_ready_q  <= '0;
      gnt_id_q     <= '0;
      sweep_done_q <= 1'b0;
      rr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      dec_addr_q   <= dec_addr_d;
      dec_en_q     <= dec_en_d;
      req_ready_q  <= req_ready_d;
      gnt_id_q     <= gnt_id_d;
      sweep_done_q <= sweep_done_d;
      rr_ptr_q     <= rr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sweep_start) begin
          state_d = StSweepOn;
        end else if (found) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (hold_cnt_q == '0) state_d = StIdle;
      end
      StSweepOn: begin
        if (hold_cnt_q == '0) state_d = StSweepGap;
      end
      StSweepGap: begin
        state_d = (sweep_addr_q == AddrLast) ? StIdle : StSweepOn;
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    dec_addr_d   = dec_addr_q;
    dec_en_d     = dec_en_q;
    req_ready_d  = '0;
    gnt_id_d     = gnt_id_q;
    sweep_done_d = 1'b0;
    rr_ptr_d     = rr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    sweep_addr_d = sweep_addr_q;
    case (state_q)
      StIdle: begin
        if (sweep_start) begin
          dec_addr_d = '0;
          dec_en_d   = 1'b1;
          hold_cnt_d = HoldInit;
        end else if (found) begin
          req_ready_d[pick] = 1'b1;
          dec_addr_d        = addr_arr[pick];
          dec_en_d          = 1'b1;
          gnt_id_d          = pick;
          rr_ptr_d          = (pick == IdLast) ? '0 : pick + 1'b1;
          hold_cnt_d        = HoldInit;
        end else begin
          dec_en_d = 1'b0;
        end
      end
      StHold, StSweepOn: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
          dec_en_d = 1'b0;
        end
      end
      StSweepGap: begin
        if (sweep_addr_q == AddrLast) begin
          sweep_done_d = 1'b1;
          sweep_addr_d = '0;
        end else begin
          sweep_addr_d = sweep_addr_q + 1'b1;
          dec_addr_d   = sweep_addr_q + 1'b1;
          dec_en_d     = 1'b1;
          hold_cnt_d   = HoldInit;
        end
      end
      default: begin
        dec_en_d = 1'b0;
      end
    endcase
  end

  assign dec_addr   = dec_addr_q;
  assign dec_en     = dec_en_q;
  assign req_ready  = req_ready_q;
  assign gnt_id     = gnt_id_q;
  assign sweep_done = sweep_done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/decoder_arbiter.md
Name: decoder_arbiter

Overview:
Shares one 5-to-32 wordline decoder (inputs A/clk, one-hot Z) between NREQ requesters.
- Requesters are served round-robin.
- Each granted address is driven for HOLD_CYCLES cycles, followed by a mandatory dead cycle, so two wordlines never overlap.
- A sweep mode walks every decoder address in order, for bring-up and decoder checks.
- Sits between the array access ports and the decoder; dec_addr drives the decoder A input.

Parameters:
NREQ, 4, number of requesters (>=2).
ADDR_W, 5, decoder address width; the decoder has 2^ADDR_W outputs.
HOLD_CYCLES, 2, cycles dec_en stays high per access (>=1).

Ports:
clk  in  1  single clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  per-requester request.
req_addr  in  NREQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
req_ready  out  NREQ  one-hot, one-cycle accept pulse.
sweep_start  in  1  request a full address sweep.
dec_addr  out  ADDR_W  registered address to decoder A.
dec_en  out  1  registered wordline enable.
gnt_id  out  clog2(NREQ)  index of the current owner.
busy  out  1  high whenever state != IDLE.
sweep_done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge.
- Reset values: dec_addr=0, dec_en=0, req_ready=0, gnt_id=0, busy=0, sweep_done=0, rr_ptr=0, hold_cnt=0, sweep_addr=0, state=IDLE.
- States: IDLE, HOLD, SWEEP_ON, SWEEP_GAP.
- IDLE, arbitration, priority order:
  - If sweep_start=1: go to SWEEP_ON with dec_addr=0, dec_en=1, hold_cnt=HOLD_CYCLES-1. Sweep has priority over requests; no req_ready is issued.
  - Else if any req_valid: select k = first valid index at or after rr_ptr, wrapping modulo NREQ.
  - On that edge register: req_ready[k]=1 (one cycle), dec_addr=req_addr[k], dec_en=1, gnt_id=k, rr_ptr=(k+1) mod NREQ, hold_cnt=HOLD_CYCLES-1. Go to HOLD.
  - Else: dec_en=0.
- Latency: a valid sampled at edge t gives dec_en=1 and req_ready=1 visible after edge t.
- HOLD:
  - If hold_cnt!=0, decrement.
  - If hold_cnt==0, set dec_en=0 and go to IDLE. dec_addr keeps its value; gnt_id keeps its value.
  - Net effect: dec_en is high for exactly HOLD_CYCLES cycles, then low for at least 1 cycle.
  - Sustained throughput: one grant per HOLD_CYCLES+1 cycles.
- Requester rules:
  - Hold req_valid and req_addr stable until req_ready.
  - Dropping req_valid before req_ready withdraws the request; this is legal.
  - req_valid high in the cycle after req_ready is a new request.
- SWEEP_ON: dec_addr=sweep_addr, dec_en=1 for HOLD_CYCLES cycles, then go to SWEEP_GAP with dec_en=0.
- SWEEP_GAP: one cycle.
  - If sweep_addr == 2^ADDR_W-1: pulse sweep_done=1, reset sweep_addr=0, go to IDLE.
  - Else: increment sweep_addr, set dec_addr=sweep_addr+1, dec_en=1, go to SWEEP_ON.
- A full sweep takes 2^ADDR_W*(HOLD_CYCLES+1) cycles from the first dec_en to sweep_done.
- sweep_start is level-sampled only in IDLE and ignored in all other states. Requests are stalled during a sweep (req_ready=0). rr_ptr is unchanged by a sweep.
- Simultaneous events in IDLE: sweep_start together with req_valid means the sweep wins; requests wait.
- Reset mid-operation (HOLD or SWEEP): on the next edge all outputs take their reset values.
  - No sweep_done and no further req_ready are issued.
  - The in-flight access is abandoned.
- Invariant: dec_en never stays high across an address change. A dead cycle always separates two accesses.

Test Plan:
1. Reset values: assert reset 3 cycles -> dec_en=0, dec_addr=0, req_ready=0, busy=0, sweep_done=0; the decoder shows Z=32'h1 with dec_en low.
2. Single request: req_valid=4'b0100, req_addr[2]=5'd19, HOLD_CYCLES=2 -> req_ready=4'b0100 for 1 cycle, gnt_id=2, dec_addr=19, dec_en high 2 cycles then low 1; decoder Z=1<<19 during enable.
3. Round robin and wrap: all 4 valid continuously from reset -> grants in order 0,1,2,3,0; consecutive dec_en rising edges 3 cycles apart; each requester's ready is exactly one cycle.
4. Pointer skip and withdraw: after granting 1, assert only valid[0] and valid[3] -> grant 3 then 0. Raise valid[2] then drop it before ready -> no req_ready[2].
5. Sweep: sweep_start with valid[1] pending -> dec_addr steps 0..31, Z=1<<i each step, no req_ready during the sweep; sweep_done pulses at cycle 96 (HOLD=2); then requester 1 is granted.
6. Reset mid-sweep at address 10 -> next cycle dec_en=0, dec_addr=0, busy=0, no sweep_done. A fresh sweep restarts from 0.
